// File: rtl/rv32_pkg.sv
// ---------------------------------------------------------------------------
// rv32_pkg
// Shared types for the fetch front end.
//   NOP_INSTR      : canonical RV32I NOP (addi x0, x0, 0) shown to decode when idle
//   fetch_state_t  : fetch control state (boot, running, halted on misaligned target)
//   fetch_entry_t  : one buffered fetch result, {pc, inst}
// ---------------------------------------------------------------------------
package rv32_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_BOOT,
    FS_RUN,
    FS_FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO of fetch_entry_t used as the instruction buffer between
// the imem response port and decode. The head is visible combinationally.
// clr empties the FIFO and takes priority over push/pop in the same cycle.
// The caller never pushes when full nor pops when empty.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (control only)
//   clr           synchronous clear
//   push, wdata   write one entry
//   pop           retire the head entry
//   rdata         head entry
//   empty         no entries held
//   count         number of entries held (0..DEPTH)
// ---------------------------------------------------------------------------
module fetch_fifo
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  fetch_entry_t               wdata,
  input  logic                       pop,
  output fetch_entry_t               rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  cnt;

  // Storage carries data only; it needs no reset.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
// Owns the architectural fetch PC. Issues word fetches on a valid/ready imem
// port, buffers in-order responses in fetch_fifo, presents {pc, inst} to
// decode, and applies EX redirects (PCSel) with same-cycle IF/ID and ID/EX
// flushes. Responses to requests issued before a redirect are counted in
// drop_cnt and discarded when they arrive.
// A redirect to a non word-aligned target halts fetching (FS_FAULT) until a
// redirect to an aligned target arrives.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   imem_req_valid/ready/addr    fetch request channel
//   imem_rsp_valid/data          in-order response channel (always accepted)
//   PCSel, target_EX             EX redirect request and target
//   stall_IF                     hold the decode-side output
//   inst_valid_ID, inst_ID, pc_ID  decode-side instruction (NOP when invalid)
//   flush_IF_ID, flush_ID_EX     pipeline kills, asserted in redirect cycles
//   fetch_misalign               fetch halted on a misaligned target
// Optional build macro FETCH_PERF_CNT_EN adds redirect_cnt and
// drop_cnt_total (redirect cycles and discarded responses, wrap at 2^32).
// ---------------------------------------------------------------------------
module fetch_pc_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        PCSel,
  input  logic [31:0] target_EX,
  input  logic        stall_IF,
  output logic        inst_valid_ID,
  output logic [31:0] inst_ID,
  output logic [31:0] pc_ID,
  output logic        flush_IF_ID,
  output logic        flush_ID_EX,
  output logic        fetch_misalign
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] redirect_cnt,
  output logic [31:0] drop_cnt_total
`endif
);

  localparam int             CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]    DEPTH_L = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0]  MAX_L   = CW'(MAX_OUTSTANDING);

  fetch_state_t   state_q;
  fetch_state_t   state_d;
  logic [31:0]    pc;
  logic [31:0]    rsp_pc;
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  drop_cnt;

  logic           target_misaligned;
  logic [CW:0]    occupancy;
  logic           req_fire;
  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  fetch_entry_t   fifo_head;
  fetch_entry_t   fifo_wdata;

  assign target_misaligned = |target_EX[1:0];
  // Requests already accepted plus entries already buffered must fit the FIFO,
  // so every response that is not dropped always finds a free slot.
  assign occupancy = {1'b0, outstanding} + {1'b0, fifo_count};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FS_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    imem_req_valid = 1'b0;
    fetch_misalign = 1'b0;
    flush_IF_ID    = PCSel;
    flush_ID_EX    = PCSel;
    case (state_q)
      FS_BOOT: begin
        state_d = (PCSel && target_misaligned) ? FS_FAULT : FS_RUN;
      end
      FS_RUN: begin
        imem_req_valid = !PCSel && (outstanding < MAX_L) && (occupancy < DEPTH_L);
        if (PCSel && target_misaligned) begin
          state_d = FS_FAULT;
        end
      end
      FS_FAULT: begin
        fetch_misalign = 1'b1;
        if (PCSel && !target_misaligned) begin
          state_d = FS_RUN;
        end
      end
      default: begin
        state_d = FS_BOOT;
      end
    endcase
  end

  assign imem_req_addr = pc;
  assign req_fire      = imem_req_valid && imem_req_ready;
  // A response arriving in a redirect cycle is stale and never pushed.
  assign fifo_push     = imem_rsp_valid && !PCSel && (drop_cnt == '0);
  assign fifo_pop      = !fifo_empty && !stall_IF && !PCSel;
  assign fifo_wdata    = '{pc: rsp_pc, inst: imem_rsp_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (PCSel) begin
        pc       <= target_EX;
        rsp_pc   <= target_EX;
        // Everything still in flight after this cycle belongs to the old path.
        drop_cnt <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) begin
          pc <= pc + 32'd4;
        end
        if (fifo_push) begin
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (imem_rsp_valid && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (PCSel),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // When nothing is buffered, pc_ID points at the next expected response.
  assign inst_valid_ID = !fifo_empty;
  assign inst_ID       = fifo_empty ? NOP_INSTR : fifo_head.inst;
  assign pc_ID         = fifo_empty ? rsp_pc    : fifo_head.pc;

`ifdef FETCH_PERF_CNT_EN
  logic rsp_dropped;
  assign rsp_dropped = imem_rsp_valid && (PCSel || (drop_cnt != '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_cnt   <= '0;
      drop_cnt_total <= '0;
    end else begin
      redirect_cnt   <= redirect_cnt + 32'(PCSel);
      drop_cnt_total <= drop_cnt_total + 32'(rsp_dropped);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        PCSel;
  logic [31:0] target_EX;
  logic        stall_IF;
  logic        inst_valid_ID;
  logic [31:0] inst_ID;
  logic [31:0] pc_ID;
  logic        flush_IF_ID;
  logic        flush_ID_EX;
  logic        fetch_misalign;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] redirect_cnt;
  logic [31:0] drop_cnt_total;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] pend[$];
  logic        mem_hold;
  logic        fire_s;
  logic [31:0] addr_s;

  fetch_pc_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .PCSel          (PCSel),
    .target_EX      (target_EX),
    .stall_IF       (stall_IF),
    .inst_valid_ID  (inst_valid_ID),
    .inst_ID        (inst_ID),
    .pc_ID          (pc_ID),
    .flush_IF_ID    (flush_IF_ID),
    .flush_ID_EX    (flush_ID_EX),
    .fetch_misalign (fetch_misalign)
`ifdef FETCH_PERF_CNT_EN
    ,
    .redirect_cnt   (redirect_cnt),
    .drop_cnt_total (drop_cnt_total)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  // One-cycle-latency memory: a request accepted at an edge is answered
  // from just after that edge until the following edge (unless held).
  task automatic mem_drive();
    imem_rsp_valid = !mem_hold && (pend.size() > 0);
    imem_rsp_data  = (pend.size() > 0) ? inst_of(pend[0]) : 32'h0;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    fire_s = imem_req_valid & imem_req_ready;
    addr_s = imem_req_addr;
    @(posedge clk);
    #1;
    if (imem_rsp_valid) void'(pend.pop_front());
    if (fire_s) pend.push_back(addr_s);
    mem_drive();
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    PCSel          = 1'b0;
    target_EX      = 32'h0;
    stall_IF       = 1'b0;
    imem_req_ready = 1'b1;
    mem_hold       = 1'b0;
    pend.delete();
    mem_drive();
    step();
    step();
    rst = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    PCSel          = 1'b0;
    target_EX      = 32'h0;
    stall_IF       = 1'b0;
    imem_req_ready = 1'b1;
    mem_hold       = 1'b0;
    pend.delete();
    mem_drive();
    step();
    checks++;
    if ({imem_req_valid, imem_req_addr, inst_valid_ID} !== {1'b0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_req: valid/addr/ivalid got %b/%h/%b want 0/00000000/0",
               imem_req_valid, imem_req_addr, inst_valid_ID);
    end
    checks++;
    if ({inst_ID, pc_ID} !== {NOP_INSTR, 32'h0}) begin
      errors++;
      $display("FAIL reset_id: inst/pc got %h/%h want 00000013/00000000", inst_ID, pc_ID);
    end
    checks++;
    if ({flush_IF_ID, flush_ID_EX, fetch_misalign} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: flushes/misalign got %b%b%b want 000",
               flush_IF_ID, flush_ID_EX, fetch_misalign);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if ({redirect_cnt, drop_cnt_total} !== 64'h0) begin
      errors++;
      $display("FAIL reset_perf: got %0d/%0d want 0/0", redirect_cnt, drop_cnt_total);
    end
`endif
    rst = 1'b0;
    settle();
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL boot_no_req: valid got %b want 0", imem_req_valid);
    end
  endtask

  // Continues straight out of test_reset (first cycle after release).
  task automatic test_basic_fetch();
    step();
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL basic_req0: valid/addr got %b/%h want 1/00000000", imem_req_valid, imem_req_addr);
    end
    step();
    checks++;
    if ({imem_req_valid, imem_req_addr, inst_valid_ID} !== {1'b1, 32'h4, 1'b0}) begin
      errors++;
      $display("FAIL basic_req4: valid/addr/ivalid got %b/%h/%b want 1/00000004/0",
               imem_req_valid, imem_req_addr, inst_valid_ID);
    end
    step();
    checks++;
    if ({imem_req_valid, inst_valid_ID, pc_ID, inst_ID} !== {1'b0, 1'b1, 32'h0, inst_of(32'h0)}) begin
      errors++;
      $display("FAIL basic_id0: valid/ivalid/pc/inst got %b/%b/%h/%h want 0/1/00000000/%h",
               imem_req_valid, inst_valid_ID, pc_ID, inst_ID, inst_of(32'h0));
    end
    step();
    checks++;
    if ({imem_req_valid, imem_req_addr, pc_ID, inst_ID} !== {1'b1, 32'h8, 32'h4, inst_of(32'h4)}) begin
      errors++;
      $display("FAIL basic_req8_id4: valid/addr/pc/inst got %b/%h/%h/%h want 1/00000008/00000004/%h",
               imem_req_valid, imem_req_addr, pc_ID, inst_ID, inst_of(32'h4));
    end
  endtask

  // Continues from test_basic_fetch with a request for 0x8 pending.
  task automatic test_ready_hold();
    imem_req_ready = 1'b0;
    settle();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8}) begin
        errors++;
        $display("FAIL hold_req[%0d]: valid/addr got %b/%h want 1/00000008", i, imem_req_valid, imem_req_addr);
      end
      step();
    end
    imem_req_ready = 1'b1;
    settle();
    step();
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'hC}) begin
      errors++;
      $display("FAIL hold_next: valid/addr got %b/%h want 1/0000000c", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    mem_hold = 1'b1;
    step();
    step();
    step();
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_maxout: valid got %b want 0", imem_req_valid);
    end
    PCSel     = 1'b1;
    target_EX = 32'h100;
    settle();
    checks++;
    if ({flush_IF_ID, flush_ID_EX, imem_req_valid} !== 3'b110) begin
      errors++;
      $display("FAIL redir_flush: flushes/valid got %b%b%b want 110", flush_IF_ID, flush_ID_EX, imem_req_valid);
    end
    step();
    PCSel    = 1'b0;
    mem_hold = 1'b0;
    mem_drive();
    settle();
    checks++;
    if ({flush_IF_ID, flush_ID_EX, imem_req_valid, inst_valid_ID} !== 4'b0000) begin
      errors++;
      $display("FAIL redir_after: flushes/valid/ivalid got %b%b%b%b want 0000",
               flush_IF_ID, flush_ID_EX, imem_req_valid, inst_valid_ID);
    end
    step();
    checks++;
    if ({imem_req_valid, imem_req_addr, inst_valid_ID} !== {1'b1, 32'h100, 1'b0}) begin
      errors++;
      $display("FAIL redir_req100: valid/addr/ivalid got %b/%h/%b want 1/00000100/0",
               imem_req_valid, imem_req_addr, inst_valid_ID);
    end
    step();
    checks++;
    if ({imem_req_valid, imem_req_addr, inst_valid_ID} !== {1'b1, 32'h104, 1'b0}) begin
      errors++;
      $display("FAIL redir_drop: valid/addr/ivalid got %b/%h/%b want 1/00000104/0",
               imem_req_valid, imem_req_addr, inst_valid_ID);
    end
    step();
    checks++;
    if ({inst_valid_ID, pc_ID, inst_ID} !== {1'b1, 32'h100, inst_of(32'h100)}) begin
      errors++;
      $display("FAIL redir_id100: ivalid/pc/inst got %b/%h/%h want 1/00000100/%h",
               inst_valid_ID, pc_ID, inst_ID, inst_of(32'h100));
    end
  endtask

  task automatic test_stall();
    do_reset();
    stall_IF = 1'b1;
    settle();
    step();
    step();
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({imem_req_valid, inst_valid_ID, pc_ID, inst_ID} !== {1'b0, 1'b1, 32'h0, inst_of(32'h0)}) begin
        errors++;
        $display("FAIL stall_full[%0d]: valid/ivalid/pc/inst got %b/%b/%h/%h want 0/1/00000000/%h",
                 i, imem_req_valid, inst_valid_ID, pc_ID, inst_ID, inst_of(32'h0));
      end
      step();
    end
    PCSel     = 1'b1;
    target_EX = 32'h40;
    settle();
    checks++;
    if ({flush_IF_ID, flush_ID_EX} !== 2'b11) begin
      errors++;
      $display("FAIL stall_redir_flush: got %b%b want 11", flush_IF_ID, flush_ID_EX);
    end
    step();
    PCSel = 1'b0;
    settle();
    checks++;
    if ({inst_valid_ID, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h40}) begin
      errors++;
      $display("FAIL stall_redir: ivalid/valid/addr got %b/%b/%h want 0/1/00000040",
               inst_valid_ID, imem_req_valid, imem_req_addr);
    end
    stall_IF = 1'b0;
  endtask

  task automatic test_misalign();
    do_reset();
    step();
    PCSel     = 1'b1;
    target_EX = 32'h102;
    settle();
    checks++;
    if ({flush_IF_ID, imem_req_valid, fetch_misalign} !== 3'b100) begin
      errors++;
      $display("FAIL mis_redir: flush/valid/misalign got %b%b%b want 100", flush_IF_ID, imem_req_valid, fetch_misalign);
    end
    step();
    PCSel = 1'b0;
    settle();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({fetch_misalign, imem_req_valid} !== 2'b10) begin
        errors++;
        $display("FAIL mis_fault[%0d]: misalign/valid got %b%b want 10", i, fetch_misalign, imem_req_valid);
      end
      step();
    end
    PCSel     = 1'b1;
    target_EX = 32'h200;
    settle();
    checks++;
    if ({flush_ID_EX, fetch_misalign} !== 2'b11) begin
      errors++;
      $display("FAIL mis_recover_flush: flush/misalign got %b%b want 11", flush_ID_EX, fetch_misalign);
    end
    step();
    PCSel = 1'b0;
    settle();
    checks++;
    if ({fetch_misalign, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h200}) begin
      errors++;
      $display("FAIL mis_run: misalign/valid/addr got %b/%b/%h want 0/1/00000200",
               fetch_misalign, imem_req_valid, imem_req_addr);
    end
    step();
    step();
    checks++;
    if ({inst_valid_ID, pc_ID} !== {1'b1, 32'h200}) begin
      errors++;
      $display("FAIL mis_id200: ivalid/pc got %b/%h want 1/00000200", inst_valid_ID, pc_ID);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    step();
    PCSel     = 1'b1;
    target_EX = 32'hFFFF_FFFC;
    settle();
    step();
    PCSel = 1'b0;
    settle();
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      errors++;
      $display("FAIL wrap_top: valid/addr got %b/%h want 1/fffffffc", imem_req_valid, imem_req_addr);
    end
    step();
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL wrap_zero: valid/addr got %b/%h want 1/00000000", imem_req_valid, imem_req_addr);
    end
    step();
    checks++;
    if ({inst_valid_ID, pc_ID} !== {1'b1, 32'hFFFF_FFFC}) begin
      errors++;
      $display("FAIL wrap_id: ivalid/pc got %b/%h want 1/fffffffc", inst_valid_ID, pc_ID);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step();
    PCSel     = 1'b1;
    target_EX = 32'h0;
    settle();
    step();
    PCSel    = 1'b0;
    mem_hold = 1'b1;
    settle();
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL b2b_req0: valid/addr got %b/%h want 1/00000000", imem_req_valid, imem_req_addr);
    end
    step();
    step();
    PCSel     = 1'b1;
    target_EX = 32'h100;
    settle();
    step();
    target_EX = 32'h180;
    settle();
    checks++;
    if ({flush_IF_ID, flush_ID_EX, imem_req_valid} !== 3'b110) begin
      errors++;
      $display("FAIL b2b_flush2: flushes/valid got %b%b%b want 110", flush_IF_ID, flush_ID_EX, imem_req_valid);
    end
    step();
    PCSel    = 1'b0;
    mem_hold = 1'b0;
    mem_drive();
    settle();
    step();
    step();
    checks++;
    if ({inst_valid_ID, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h184}) begin
      errors++;
      $display("FAIL b2b_dropped: ivalid/valid/addr got %b/%b/%h want 0/1/00000184",
               inst_valid_ID, imem_req_valid, imem_req_addr);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if ({redirect_cnt, drop_cnt_total} !== {32'd3, 32'd2}) begin
      errors++;
      $display("FAIL perf_counts: redirect/drop got %0d/%0d want 3/2", redirect_cnt, drop_cnt_total);
    end
`endif
    step();
    checks++;
    if ({inst_valid_ID, pc_ID, inst_ID} !== {1'b1, 32'h180, inst_of(32'h180)}) begin
      errors++;
      $display("FAIL b2b_id180: ivalid/pc/inst got %b/%h/%h want 1/00000180/%h",
               inst_valid_ID, pc_ID, inst_ID, inst_of(32'h180));
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_ready_hold();
    test_redirect();
    test_stall();
    test_misalign();
    test_wrap();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
